// File: rtl/my_keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package my_keypad_pkg;

  typedef enum logic [1:0] {StIdle, StCand, StPressed, StRel} state_e;

  typedef enum logic [1:0] {ScanNone, ScanSingle, ScanMulti} scan_res_e;

  // Nibble i holds the code for key index row*4+col.
  localparam logic [63:0] KeyMap = 64'hDF0E_C987_B654_A321;

  function automatic logic [3:0] key_map(input logic [3:0] idx);
    return KeyMap[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/my_keypad_col_scan.sv
// Row synchronizer, column rotation and per-scan NONE/SINGLE/MULTI classification.
module my_keypad_col_scan
  import my_keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 12000
) (
  input  logic      clk,
  input  logic      rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic       scan_done,
  output scan_res_e  scan_res,
  output logic [3:0] scan_code
);

  localparam int unsigned SlotW = $clog2(SCAN_DIV);
  localparam logic [SlotW-1:0] SlotLast = SlotW'(SCAN_DIV - 1);

  logic [3:0]       row_meta_q, row_sync_q;
  logic [SlotW-1:0] slot_q;
  logic [1:0]       col_q;
  logic [1:0]       hits_q, prev_hits, col_hits, tot_hits, col_row;
  logic [2:0]       hit_sum;
  logic [3:0]       code_q, code_d;
  logic             sample;

  assign sample = (slot_q == SlotLast);
  assign col_n  = ~(4'b0001 << col_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
      slot_q     <= '0;
      col_q      <= 2'd0;
      hits_q     <= 2'd0;
      code_q     <= 4'h0;
    end else begin
      row_meta_q <= row_n;
      row_sync_q <= row_meta_q;
      if (sample) begin
        slot_q <= '0;
        col_q  <= col_q + 2'd1;
        hits_q <= tot_hits;
        code_q <= code_d;
      end else begin
        slot_q <= slot_q + SlotW'(1);
      end
    end
  end

  // Hit counts saturate at 2: anything beyond one crossing is MULTI.
  always_comb begin
    col_hits = 2'd0;
    col_row  = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (!row_sync_q[r]) begin
        col_row = 2'(r);
        if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
      end
    end
    prev_hits = (col_q == 2'd0) ? 2'd0 : hits_q;
    hit_sum   = {1'b0, prev_hits} + {1'b0, col_hits};
    tot_hits  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    code_d    = (col_hits == 2'd1) ? key_map({col_row, col_q}) : code_q;
  end

  assign scan_done = sample && (col_q == 2'd3);
  assign scan_code = code_d;
  assign scan_res  = (tot_hits == 2'd0) ? ScanNone :
                     (tot_hits == 2'd1) ? ScanSingle : ScanMulti;

endmodule

// File: rtl/my_keypad_scan.sv
// Keypad top: debounce FSM, accepted key code and last-four-digit shift register.
module my_keypad_scan
  import my_keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 12000,
  parameter int unsigned DEBOUNCE_SCANS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row_n,
  output logic [3:0]  col_n,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_down,
  output logic [15:0] digits
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CntW-1:0] CntDone = CntW'(DEBOUNCE_SCANS);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic       scan_done;
  scan_res_e  scan_res;
  logic [3:0] scan_code;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]      cand_q, cand_d, key_code_q, key_code_d, acc_code;
  logic [15:0]     digits_q, digits_d;
  logic            key_valid_q, accept;

  my_keypad_col_scan #(
    .SCAN_DIV(SCAN_DIV)
  ) u_col_scan (
    .clk      (clk),
    .rst      (rst),
    .row_n    (row_n),
    .col_n    (col_n),
    .scan_done(scan_done),
    .scan_res (scan_res),
    .scan_code(scan_code)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      cand_q      <= 4'h0;
      key_code_q  <= 4'h0;
      digits_q    <= 16'h0000;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      digits_q    <= digits_d;
      key_valid_q <= accept;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    accept   = 1'b0;
    acc_code = cand_q;
    cnt_inc  = cnt_q + CntOne;
    if (scan_done) begin
      case (state_q)
        StIdle: begin
          if (scan_res == ScanSingle) begin
            cand_d = scan_code;
            if (CntOne == CntDone) begin
              accept   = 1'b1;
              acc_code = scan_code;
              state_d  = StPressed;
              cnt_d    = '0;
            end else begin
              state_d = StCand;
              cnt_d   = CntOne;
            end
          end
        end
        StCand: begin
          if (scan_res == ScanSingle && scan_code == cand_q) begin
            if (cnt_inc == CntDone) begin
              accept  = 1'b1;
              state_d = StPressed;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
        StPressed: begin
          if (scan_res == ScanNone) begin
            if (CntOne == CntDone) begin
              state_d = StIdle;
              cnt_d   = '0;
            end else begin
              state_d = StRel;
              cnt_d   = CntOne;
            end
          end
        end
        StRel: begin
          if (scan_res == ScanNone) begin
            if (cnt_inc == CntDone) begin
              state_d = StIdle;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = StPressed;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
    key_code_d = accept ? acc_code : key_code_q;
    digits_d   = accept ? {digits_q[11:0], acc_code} : digits_q;
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign digits    = digits_q;
  assign key_down  = (state_q == StPressed) || (state_q == StRel);

endmodule

// File: doc/my_keypad_scan.md
# my_keypad_scan

Scans a 4x4 matrix keypad, debounces key presses, and produces one hex key code per press. It also keeps a shift register of the last four keys entered. It sits directly upstream of the 4-digit seven-segment driver, whose `num` input takes `digits` unchanged. It replaces the external keypad LED and debounce glue for key entry.

## Interface
- `SCAN_DIV`, default 12000: clocks per column slot (1 ms at 12 MHz); must be ≥4.
- `DEBOUNCE_SCANS`, default 20: consecutive identical full scans required to accept a press or a release; must be ≥1.
- `clk` in, 1: single system clock, all logic on rising edge.
- `rst` in, 1: asynchronous, active-high reset.
- `row_n` in, 4: keypad rows, active-low (external pull-ups), asynchronous to `clk`.
- `col_n` out, 4: column drive, active-low, exactly one bit low at any time.
- `key_code` out, 4: hex code of the last accepted key.
- `key_valid` out, 1: one-cycle pulse when a press is accepted.
- `key_down` out, 1: high while an accepted key is considered held.
- `digits` out, 16: last four codes, newest in [3:0].

## Operation
- Key map (row r, col c): r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: `*`=E, 0, `#`=F, D.
- `row_n` passes through a 2-flop synchronizer before any use.
- Slot counter counts 0..SCAN_DIV-1. On wrap, the active column advances 0→1→2→3→0 (`col_n` 1110→1101→1011→0111).
- Rows are sampled at slot count SCAN_DIV-1 of each column. The four columns sampled in turn form one full scan. Scan result is one of:
  - NONE: no row low in any column.
  - SINGLE(code): exactly one row/column crossing low.
  - MULTI: two or more crossings low.
- FSM updates once per full scan, at the column-3 sample:
  - IDLE:
    - SINGLE → CAND, cand=code, cnt=1.
    - Otherwise stay.
  - CAND:
    - SINGLE with the same code → cnt+1.
    - When cnt reaches DEBOUNCE_SCANS → PRESSED, and the accept actions below fire.
    - Anything else → IDLE, cnt=0.
  - PRESSED:
    - NONE → REL, cnt=1.
    - Anything else (including MULTI or a different key) → stay; no new report.
  - REL:
    - NONE → cnt+1; at DEBOUNCE_SCANS → IDLE.
    - Anything else → PRESSED.
- With DEBOUNCE_SCANS=1, CAND accepts on its entry scan: IDLE goes straight to PRESSED. REL likewise goes straight to IDLE.
- Accept actions:
  - `key_code` ← cand.
  - `digits` ← {digits[11:0], cand}.
  - `key_valid` = 1 for exactly one cycle.
- `key_down` = 1 in PRESSED and REL, 0 in IDLE and CAND.
- Auto-repeat is not supported; holding a key yields exactly one `key_valid`.
- Arithmetic widths:
  - Slot counter: $clog2(SCAN_DIV) bits.
  - Scan counter: $clog2(DEBOUNCE_SCANS+1) bits.
  - Neither counter may overflow; compare with ==, not wrap.

## Timing
- Reset values (asserted asynchronously, held while `rst`=1):
  - `col_n`=1110.
  - FSM=IDLE, both counters 0.
  - `key_code`=0, `key_valid`=0, `key_down`=0, `digits`=0.
  - Synchronizer flops=1111.
- First column advance occurs SCAN_DIV clocks after `rst` deasserts.
- Row sample reflects pins from ≥2 cycles earlier. SCAN_DIV≥4 guarantees the column drive has settled.
- `key_valid`, `key_code`, `digits` and `key_down` all update on the same edge: the one following the accepting column-3 sample (registered, 1-cycle latency).
- Press latency from a stable press: at most (DEBOUNCE_SCANS+1)·4·SCAN_DIV + 3 clocks.
- Reset mid-press: state is discarded. A key still held is re-reported after a full debounce once reset is released.

## Structure
- Shared package `my_keypad_pkg` holds:
  - FSM state enum (IDLE, CAND, PRESSED, REL).
  - 16-entry key-map constant (row*4+col → code).
  - Scan-result encoding.
- Sub-module `my_keypad_col_scan` owns:
  - Synchronizer, slot counter and column rotation.
  - Per-scan NONE/SINGLE/MULTI classification, output as a 1-cycle `scan_done` strobe with result and code.
- The top level holds the FSM, debounce counter and output registers.

## Test plan
Benches use SCAN_DIV=4, DEBOUNCE_SCANS=3 (one full scan = 16 clocks).
- Reset: assert `rst` mid-slot → `col_n`=1110 immediately, all outputs 0; after release, `col_n` steps 1101, 1011, 0111 every 4 clocks.
- Single press: hold row1/col2 for 30 scans → exactly one `key_valid`, `key_code`=6, `digits`=0x0006, `key_down`=1 until 3 NONE scans after release.
- Bounce: hold `1` for 2 scans, release for 1 scan, repeat 5× → no `key_valid`, `key_down` stays 0.
- Multi-key: hold `1` and `2` together for 10 scans → no report; release `1` → after 3 scans `key_code`=2.
- Entry sequence: press/release 1, 2, 3, A → `digits`=0x123A; then `#` → `digits`=0x23AF; `*` maps to E.
- Reset in PRESSED: assert `rst` while holding `5` → outputs 0; keep holding after release → `key_valid` with code 5 after 3 scans.
